// File: rtl/xoodyak_pkg.sv
// Shared widths and the decrypt-gate state type for the Xoodyak datapath.
package xoodyak_pkg;

    localparam int unsigned TEXT_W  = 192;
    localparam int unsigned TAG_W   = 128;
    localparam int unsigned NONCE_W = 128;
    localparam int unsigned AD_W    = 128;
    localparam int unsigned KEY_W   = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_CHECK,
        ST_OUT
    } dec_gate_state_t;

endpackage

// File: rtl/xoodyak_tag_cmp.sv
// Constant-time 128-bit tag equality: full XOR then OR-reduce, no early exit.
module xoodyak_tag_cmp
    import xoodyak_pkg::*;
(
    input  logic [TAG_W-1:0] tag_a,
    input  logic [TAG_W-1:0] tag_b,
    output logic             equal
);

    logic [TAG_W-1:0] diff;

    // Every bit of both tags contributes regardless of where they differ.
    always_comb begin
        diff  = tag_a ^ tag_b;
        equal = ~|diff;
    end

endmodule

// File: rtl/xoodyak_dec_gate.sv
// Receive-side release gate: runs the Xoodyak core in decrypt mode and only
// releases plaintext when the recomputed tag matches the received one.
// Optional statistics counters: define XOODYAK_DEC_GATE_STATS_EN.
module xoodyak_dec_gate
    import xoodyak_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               eph1,
    input  logic               reset,
    input  logic [KEY_W-1:0]   key,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TEXT_W-1:0]  in_cipher,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [NONCE_W-1:0] in_nonce,
    input  logic [AD_W-1:0]    in_ad,
    output logic               core_start,
    output logic               core_opmode,
    output logic [TEXT_W-1:0]  core_textin,
    output logic [NONCE_W-1:0] core_nonce,
    output logic [AD_W-1:0]    core_assodata,
    output logic [KEY_W-1:0]   core_key,
    output logic [TAG_W-1:0]   core_verification_data,
    input  logic               core_done,
    input  logic [TEXT_W-1:0]  core_textout,
    input  logic [TAG_W-1:0]   core_authdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TEXT_W-1:0]  out_text,
    output logic               auth_ok,
    output logic               err_timeout,
    output logic [CNT_W-1:0]   cnt_ok,
    output logic [CNT_W-1:0]   cnt_fail
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    dec_gate_state_t   state;
    logic [7:0]        tcnt;
    logic [TEXT_W-1:0] cap_text;
    logic [TAG_W-1:0]  cap_auth;
    logic              tag_match;

    assign core_opmode = 1'b1;

    xoodyak_tag_cmp u_tag_cmp (
        .tag_a (cap_auth),
        .tag_b (core_verification_data),
        .equal (tag_match)
    );

    // Frame sequencing, field latching, result release and zeroization.
    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            state                  <= ST_IDLE;
            in_ready               <= 1'b0;
            core_start             <= 1'b0;
            core_textin            <= '0;
            core_nonce             <= '0;
            core_assodata          <= '0;
            core_key               <= '0;
            core_verification_data <= '0;
            cap_text               <= '0;
            cap_auth               <= '0;
            tcnt                   <= '0;
            out_valid              <= 1'b0;
            out_text               <= '0;
            auth_ok                <= 1'b0;
            err_timeout            <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        core_textin            <= in_cipher;
                        core_nonce             <= in_nonce;
                        core_assodata          <= in_ad;
                        core_key               <= key;
                        core_verification_data <= in_tag;
                        in_ready               <= 1'b0;
                        core_start             <= 1'b1;
                        state                  <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    tcnt  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    tcnt <= tcnt + 8'd1;
                    // core_done takes priority over an expiring timeout
                    if (core_done) begin
                        cap_text <= core_textout;
                        cap_auth <= core_authdata;
                        state    <= ST_CHECK;
                    end else if (tcnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        auth_ok     <= 1'b0;
                        out_text    <= '0;
                        out_valid   <= 1'b1;
                        state       <= ST_OUT;
                    end
                end
                ST_CHECK: begin
                    auth_ok   <= tag_match;
                    out_text  <= tag_match ? cap_text : '0;
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        core_textin            <= '0;
                        core_nonce             <= '0;
                        core_assodata          <= '0;
                        core_key               <= '0;
                        core_verification_data <= '0;
                        cap_text               <= '0;
                        cap_auth               <= '0;
                        out_valid              <= 1'b0;
                        out_text               <= '0;
                        auth_ok                <= 1'b0;
                        err_timeout            <= 1'b0;
                        in_ready               <= 1'b1;
                        state                  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef XOODYAK_DEC_GATE_STATS_EN
    // Saturating pass/fail statistics, bumped on each result handshake.
    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            cnt_ok   <= '0;
            cnt_fail <= '0;
        end else if (out_valid && out_ready) begin
            if (auth_ok) begin
                if (cnt_ok != '1) cnt_ok <= cnt_ok + 1'b1;
            end else begin
                if (cnt_fail != '1) cnt_fail <= cnt_fail + 1'b1;
            end
        end
    end
`else
    assign cnt_ok   = '0;
    assign cnt_fail = '0;
`endif

endmodule

// File: tb/tb_xoodyak_dec_gate.sv
// Self-checking bench for xoodyak_dec_gate with a toy decrypt-core stub.
module tb_xoodyak_dec_gate;
    import xoodyak_pkg::*;

    localparam int L    = 3;
    localparam int TO   = 8;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
`ifdef XOODYAK_DEC_GATE_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    localparam logic [191:0] PT_A = 192'h4d4e4f50_51525354_55565758_41424344_45464748_494a4b4c;
    localparam logic [191:0] PT_B = 192'h0123456789abcdef_fedcba9876543210_a5a55a5a3c3cc3c3;
    localparam logic [127:0] K_S  = 128'h38393a3b3c3d3e3f3031323334353637;
    localparam logic [127:0] N_S  = 128'h494a4b4c4d4e4f504142434445464748;
    localparam logic [127:0] AD_S = 128'h696a6b6c6d6e6f706162636465666768;

    logic         eph1 = 1'b0;
    logic         reset;
    logic [127:0] key;
    logic         in_valid, in_ready;
    logic [191:0] in_cipher;
    logic [127:0] in_tag, in_nonce, in_ad;
    logic         core_start, core_opmode, core_done;
    logic [191:0] core_textin, core_textout;
    logic [127:0] core_nonce, core_assodata, core_key, core_verification_data, core_authdata;
    logic         out_valid, out_ready, auth_ok, err_timeout;
    logic [191:0] out_text;
    logic [CW-1:0] cnt_ok, cnt_fail;

    always #5 eph1 = ~eph1;

    xoodyak_dec_gate #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .eph1(eph1), .reset(reset), .key(key),
        .in_valid(in_valid), .in_ready(in_ready), .in_cipher(in_cipher),
        .in_tag(in_tag), .in_nonce(in_nonce), .in_ad(in_ad),
        .core_start(core_start), .core_opmode(core_opmode),
        .core_textin(core_textin), .core_nonce(core_nonce),
        .core_assodata(core_assodata), .core_key(core_key),
        .core_verification_data(core_verification_data),
        .core_done(core_done), .core_textout(core_textout), .core_authdata(core_authdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text),
        .auth_ok(auth_ok), .err_timeout(err_timeout),
        .cnt_ok(cnt_ok), .cnt_fail(cnt_fail)
    );

    // Toy stand-in for the Xoodyak keystream and tag.
    function automatic logic [191:0] ks(input logic [127:0] k, input logic [127:0] n);
        return {k ^ {n[63:0], n[127:64]}, k[127:64] ^ n[63:0]} ^ {3{64'h0f1e2d3c4b5a6978}};
    endfunction

    function automatic logic [127:0] tagf(input logic [127:0] k, input logic [127:0] n,
                                          input logic [127:0] ad, input logic [191:0] pt);
        return k ^ {n[63:0], n[127:64]} ^ {ad[126:0], ad[127]} ^ pt[191:64] ^ {pt[63:0], pt[127:64]};
    endfunction

    // Core stub: done pulse L cycles after start unless hung.
    logic         stub_done, spur_done, hang;
    logic [191:0] stub_text, stub_pt;
    logic [127:0] stub_auth;
    int           rem;
    assign stub_pt       = core_textin ^ ks(core_key, core_nonce);
    assign core_done     = stub_done | spur_done;
    assign core_textout  = stub_text;
    assign core_authdata = stub_auth;

    always @(posedge eph1 or posedge reset) begin
        if (reset) begin
            rem <= 0; stub_done <= 1'b0; stub_text <= '0; stub_auth <= '0;
        end else begin
            stub_done <= 1'b0;
            if (core_start && !hang) rem <= L - 1;
            else if (rem != 0) begin
                rem <= rem - 1;
                if (rem == 1) begin
                    stub_done <= 1'b1;
                    stub_text <= stub_pt;
                    stub_auth <= tagf(core_key, core_nonce, core_assodata, stub_pt);
                end
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct { logic [191:0] text; logic auth; logic err; } exp_t;
    exp_t sbq[$];

    // Scoreboard: compare each result at its handshake.
    always @(negedge eph1) begin
        if (!reset && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_out_valid", 192'(out_valid), 192'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("sb_out_text", out_text, e.text);
                check("sb_auth_ok", 192'(auth_ok), 192'(e.auth));
                check("sb_err_timeout", 192'(err_timeout), 192'(e.err));
            end
        end
    end

    int m_ok = 0;
    int m_fail = 0;

    task automatic model_count(input logic ok);
        if (ok) m_ok = (m_ok < CMAX) ? m_ok + 1 : CMAX;
        else    m_fail = (m_fail < CMAX) ? m_fail + 1 : CMAX;
    endtask

    task automatic chk_cnt(input string nm);
        check({nm, "_cnt_ok"}, 192'(cnt_ok), STATS_ON ? 192'(m_ok) : 192'd0);
        check({nm, "_cnt_fail"}, 192'(cnt_fail), STATS_ON ? 192'(m_fail) : 192'd0);
    endtask

    task automatic drive_frame(input logic [191:0] pt, input logic [127:0] flip,
                               input logic exp_auth, input logic exp_err, input logic push);
        exp_t e;
        @(negedge eph1);
        in_cipher = pt ^ ks(K_S, N_S);
        in_tag    = tagf(K_S, N_S, AD_S, pt) ^ flip;
        in_nonce  = N_S;
        in_ad     = AD_S;
        key       = K_S;
        in_valid  = 1'b1;
        if (push) begin
            e.auth = exp_auth;
            e.err  = exp_err;
            e.text = exp_auth ? pt : '0;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_accept();
        int n = 0;
        while (!in_ready && n < 300) begin @(negedge eph1); n++; end
        if (!in_ready) begin
            check("accept_wait_expired", 192'(in_ready), 192'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge eph1); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_lat(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge eph1); #1; lat++; end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 300) begin @(negedge eph1); n++; end
        if (sbq.size() != 0) begin
            check("drain_expired", 192'(sbq.size()), 192'd0);
            sbq.delete();
        end
        @(negedge eph1);
    endtask

    typedef struct { logic [191:0] pt; logic [127:0] flip; logic exp_auth; } vec_t;
    vec_t vt[5];

    initial begin
        int lat;
        logic [191:0] hold_text;
        logic         hold_auth;

        vt[0] = '{PT_A, 128'h0, 1'b1};
        vt[1] = '{PT_A, 128'h1, 1'b0};
        vt[2] = '{192'h0, 128'h0, 1'b1};
        vt[3] = '{{192{1'b1}}, {1'b1, 127'h0}, 1'b0};
        vt[4] = '{PT_B, 128'h0, 1'b1};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; spur_done = 1'b0; hang = 1'b0;
        key = '0; in_cipher = '0; in_tag = '0; in_nonce = '0; in_ad = '0;

        repeat (2) @(negedge eph1);
        check("rst_in_ready", 192'(in_ready), 192'd0);
        check("rst_out_valid", 192'(out_valid), 192'd0);
        check("rst_core_start", 192'(core_start), 192'd0);
        check("rst_out_text", out_text, 192'd0);
        check("rst_flags", {auth_ok, err_timeout}, 192'd0);
        check("rst_cnts", {cnt_ok, cnt_fail}, 192'd0);
        check("rst_core_textin", core_textin, 192'd0);
        reset = 1'b0;
        @(posedge eph1); #1;
        check("in_ready_after_rst", 192'(in_ready), 192'd1);

        for (int i = 0; i < 5; i++) begin
            drive_frame(vt[i].pt, vt[i].flip, vt[i].exp_auth, 1'b0, 1'b1);
            wait_accept();
            wait_lat(lat);
            check("vec_latency", 192'(lat), 192'(L + 3));
            wait_drain();
            model_count(vt[i].exp_auth);
            chk_cnt("vec");
        end

        hang = 1'b1;
        drive_frame(PT_A, 128'h0, 1'b0, 1'b1, 1'b1);
        wait_accept();
        wait_drain();
        hang = 1'b0;
        model_count(1'b0);
        check("to_back_idle", 192'(in_ready), 192'd1);
        chk_cnt("to");

        @(posedge eph1); #1;
        out_ready = 1'b0;
        drive_frame(PT_A, 128'h0, 1'b1, 1'b0, 1'b1);
        wait_accept();
        lat = 0;
        while (!out_valid && lat < 100) begin @(negedge eph1); lat++; end
        check("bp_out_valid_seen", 192'(out_valid), 192'd1);
        hold_text = out_text;
        hold_auth = auth_ok;
        drive_frame(PT_B, 128'h0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            spur_done = (i == 3);
            @(negedge eph1);
            check("bp_out_valid", 192'(out_valid), 192'd1);
            check("bp_in_ready", 192'(in_ready), 192'd0);
            check("bp_text_stable", out_text, hold_text);
            check("bp_auth_stable", 192'(auth_ok), 192'(hold_auth));
        end
        spur_done = 1'b0;
        @(posedge eph1); #1;
        out_ready = 1'b1;
        wait_accept();
        wait_drain();
        model_count(1'b1);
        model_count(1'b1);
        chk_cnt("bp");

        drive_frame(PT_A, 128'h0, 1'b1, 1'b0, 1'b0);
        wait_accept();
        @(posedge eph1); #3;
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 192'(out_valid), 192'd0);
        check("mid_rst_in_ready", 192'(in_ready), 192'd0);
        check("mid_rst_core_key", 192'(core_key), 192'd0);
        check("mid_rst_core_tag", 192'(core_verification_data), 192'd0);
        check("mid_rst_core_textin", core_textin, 192'd0);
        check("mid_rst_cnts", {cnt_ok, cnt_fail}, 192'd0);
        m_ok = 0; m_fail = 0;
        @(negedge eph1);
        reset = 1'b0;
        repeat (15) @(negedge eph1);
        check("mid_rst_no_out", 192'(out_valid), 192'd0);

        for (int i = 0; i < 6; i++) begin
            drive_frame(i[0] ? PT_B : PT_A, 128'h0, 1'b1, 1'b0, 1'b1);
            wait_accept();
            wait_lat(lat);
            check("post_rst_latency", 192'(lat), 192'(L + 3));
            wait_drain();
            model_count(1'b1);
        end
        check("sat_cnt_ok", 192'(cnt_ok), STATS_ON ? 192'(CMAX) : 192'd0);
        chk_cnt("sat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit actual=expired required=finished");
        $fatal(1, "time limit");
    end

endmodule
